// File: rtl/accel_job_controller.sv
// accel_job_controller: runs one accelerator job at a time, from frame capture through result handoff
module accel_job_controller #(
   parameter int USER_DATA_BYTES = 785,
   parameter int IP_ADDR_WIDTH   = 32,
   parameter int MAC_ADDR_WIDTH  = 48,
   parameter int RESULT_WIDTH    = 8,
   parameter int TIMEOUT_CYCLES  = 100000,
   parameter int COUNTER_WIDTH   = 16
) (
   input  logic                         ACLK,
   input  logic                         ARESET,
   input  logic                         FRAME_READY,
   input  logic [USER_DATA_BYTES*8-1:0] DATA_FRAME,
   input  logic [IP_ADDR_WIDTH-1:0]     SRC_IP_ADDRESS,
   input  logic [MAC_ADDR_WIDTH-1:0]    SRC_MAC_ADDRESS,
   output logic                         ACCEL_START,
   output logic [USER_DATA_BYTES*8-1:0] ACCEL_DATA,
   input  logic                         ACCEL_DONE,
   input  logic [RESULT_WIDTH-1:0]      ACCEL_RESULT,
   output logic                         ACCEL_ABORT,
   output logic                         TX_VALID,
   input  logic                         TX_READY,
   output logic [IP_ADDR_WIDTH-1:0]     TX_DST_IP,
   output logic [MAC_ADDR_WIDTH-1:0]    TX_DST_MAC,
   output logic [RESULT_WIDTH-1:0]      TX_RESULT,
   output logic                         BUSY,
   output logic [COUNTER_WIDTH-1:0]     DROP_COUNT,
   output logic [COUNTER_WIDTH-1:0]     TIMEOUT_COUNT
);
   localparam int DW = USER_DATA_BYTES * 8;
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [COUNTER_WIDTH-1:0] CONE = COUNTER_WIDTH'(1);
   typedef enum logic [1:0] {IDLE, START, COMPUTE, SEND} state_t;
   state_t                     r_state;
   logic                       r_start;
   logic                       r_abort;
   logic                       r_valid;
   logic                       r_busy;
   logic [DW-1:0]              r_data;
   logic [IP_ADDR_WIDTH-1:0]   r_ip;
   logic [MAC_ADDR_WIDTH-1:0]  r_mac;
   logic [RESULT_WIDTH-1:0]    r_result;
   logic [TW-1:0]              r_timer;
   logic [COUNTER_WIDTH-1:0]   r_drop;
   logic [COUNTER_WIDTH-1:0]   r_tocnt;
   // Job sequencer; the timer is 0 in START and 1 in the first COMPUTE cycle so the abort lands TIMEOUT_CYCLES after the start pulse
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state  <= IDLE;
         r_start  <= 1'b0;
         r_abort  <= 1'b0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
         r_data   <= '0;
         r_ip     <= '0;
         r_mac    <= '0;
         r_result <= '0;
         r_timer  <= '0;
         r_drop   <= '0;
         r_tocnt  <= '0;
      end else begin
         r_start <= 1'b0;
         r_abort <= 1'b0;
         if (FRAME_READY && r_state != IDLE && r_drop != '1)
            r_drop <= r_drop + CONE;
         case (r_state)
            IDLE:
               if (FRAME_READY) begin
                  r_data  <= DATA_FRAME;
                  r_ip    <= SRC_IP_ADDRESS;
                  r_mac   <= SRC_MAC_ADDRESS;
                  r_start <= 1'b1;
                  r_busy  <= 1'b1;
                  r_timer <= '0;
                  r_state <= START;
               end
            START: begin
               r_timer <= TW'(1);
               r_state <= COMPUTE;
            end
            COMPUTE:
               if (ACCEL_DONE) begin
                  r_result <= ACCEL_RESULT;
                  r_valid  <= 1'b1;
                  r_state  <= SEND;
               end else if (r_timer == TLAST) begin
                  r_abort <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
                  if (r_tocnt != '1)
                     r_tocnt <= r_tocnt + CONE;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            SEND:
               if (TX_READY) begin
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign ACCEL_START   = r_start;
   assign ACCEL_DATA    = r_data;
   assign ACCEL_ABORT   = r_abort;
   assign TX_VALID      = r_valid;
   assign TX_DST_IP     = r_ip;
   assign TX_DST_MAC    = r_mac;
   assign TX_RESULT     = r_result;
   assign BUSY          = r_busy;
   assign DROP_COUNT    = r_drop;
   assign TIMEOUT_COUNT = r_tocnt;
endmodule

// File: tb/tb_accel_job_controller.sv
// tb_accel_job_controller: randomized job scenarios with a queue scoreboard and an event monitor
module tb_accel_job_controller;
   localparam int UB = 785;
   localparam int IW = 32;
   localparam int MW = 48;
   localparam int RW = 8;
   localparam int T = 20;
   localparam int CW = 2;
   localparam int DW = UB * 8;
   localparam int SAT = (1 << CW) - 1;
   logic ACLK = 1'b0;
   logic ARESET = 1'b0;
   logic FRAME_READY = 1'b0;
   logic [DW-1:0] DATA_FRAME = '0;
   logic [IW-1:0] SRC_IP_ADDRESS = '0;
   logic [MW-1:0] SRC_MAC_ADDRESS = '0;
   logic ACCEL_DONE = 1'b0;
   logic [RW-1:0] ACCEL_RESULT = '0;
   logic TX_READY = 1'b0;
   logic ACCEL_START, ACCEL_ABORT, TX_VALID, BUSY;
   logic [DW-1:0] ACCEL_DATA;
   logic [IW-1:0] TX_DST_IP;
   logic [MW-1:0] TX_DST_MAC;
   logic [RW-1:0] TX_RESULT;
   logic [CW-1:0] DROP_COUNT, TIMEOUT_COUNT;
   accel_job_controller #(
      .USER_DATA_BYTES(UB), .IP_ADDR_WIDTH(IW), .MAC_ADDR_WIDTH(MW),
      .RESULT_WIDTH(RW), .TIMEOUT_CYCLES(T), .COUNTER_WIDTH(CW)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET), .FRAME_READY(FRAME_READY), .DATA_FRAME(DATA_FRAME),
      .SRC_IP_ADDRESS(SRC_IP_ADDRESS), .SRC_MAC_ADDRESS(SRC_MAC_ADDRESS),
      .ACCEL_START(ACCEL_START), .ACCEL_DATA(ACCEL_DATA), .ACCEL_DONE(ACCEL_DONE),
      .ACCEL_RESULT(ACCEL_RESULT), .ACCEL_ABORT(ACCEL_ABORT), .TX_VALID(TX_VALID),
      .TX_READY(TX_READY), .TX_DST_IP(TX_DST_IP), .TX_DST_MAC(TX_DST_MAC),
      .TX_RESULT(TX_RESULT), .BUSY(BUSY), .DROP_COUNT(DROP_COUNT), .TIMEOUT_COUNT(TIMEOUT_COUNT)
   );
   always #5 ACLK = ~ACLK;
   int cyc = 0;
   always @(posedge ACLK) cyc <= cyc + 1;
   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } st_t;
   typedef struct {
      logic [IW-1:0] ip;
      logic [MW-1:0] mac;
      logic [RW-1:0] res;
      logic [DW-1:0] data;
      int            cyc;
   } tx_t;
   st_t exp_start[$];
   tx_t exp_tx[$];
   int  exp_abort[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   int  m_drop = 0;
   int  m_to = 0;
   function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
      end
   endfunction
   function automatic void chk_data(string n, logic [DW-1:0] a, logic [DW-1:0] e);
      int b;
      n_cmp++;
      if (a !== e) begin
         b = 0;
         for (int j = UB - 1; j >= 0; j--) if (a[j*8+:8] !== e[j*8+:8]) b = j;
         n_bad++;
         $display("FAIL %s: byte %0d got %0h expected %0h (cycle %0d)", n, b, a[b*8+:8], e[b*8+:8], cyc);
      end
   endfunction
   function automatic void unexpected(string n);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: output seen with nothing expected (cycle %0d)", n, cyc);
   endfunction
   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] r;
      for (int j = 0; j < UB; j++) r[j*8+:8] = 8'($urandom);
      return r;
   endfunction
   st_t m_s;
   tx_t m_t;
   int  m_a;
   // Monitor: every start, abort and presented result is matched against the scoreboard
   always @(negedge ACLK) if (!ARESET) begin
      if (ACCEL_START) begin
         if (exp_start.size() == 0) unexpected("start");
         else begin
            m_s = exp_start.pop_front();
            chk("start_cycle", 64'(cyc), 64'(m_s.cyc));
            chk_data("start_data", ACCEL_DATA, m_s.data);
         end
      end
      if (ACCEL_ABORT) begin
         if (exp_abort.size() == 0) unexpected("abort");
         else begin
            m_a = exp_abort.pop_front();
            chk("abort_cycle", 64'(cyc), 64'(m_a));
         end
      end
      if (TX_VALID) begin
         if (exp_tx.size() == 0) unexpected("tx_valid");
         else begin
            m_t = exp_tx[0];
            chk("tx_ip", 64'(TX_DST_IP), 64'(m_t.ip));
            chk("tx_mac", 64'(TX_DST_MAC), 64'(m_t.mac));
            chk("tx_result", 64'(TX_RESULT), 64'(m_t.res));
            chk_data("tx_accel_data", ACCEL_DATA, m_t.data);
            if (TX_READY) begin
               chk("tx_handshake_cycle", 64'(cyc), 64'(m_t.cyc));
               void'(exp_tx.pop_front());
            end
         end
      end
   end
   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask
   task automatic drop_frame();
      DATA_FRAME = rnd_data();
      SRC_IP_ADDRESS = $urandom;
      SRC_MAC_ADDRESS = MW'({$urandom, $urandom});
      if (m_drop < SAT) m_drop++;
   endtask
   // d: done offset after start (>= T means no done); w: ready delay after SEND entry (-1 = ready early)
   task automatic job(input logic [DW-1:0] data, input logic [IW-1:0] ip, input logic [MW-1:0] mac,
                      input logic [RW-1:0] res, input int d, input int w,
                      input int drop_from, input int drop_n, input int drop_pct);
      int  k, last;
      bit  to;
      st_t s;
      tx_t t;
      k = cyc + 1;
      to = d >= T;
      s.data = data;
      s.cyc = k;
      exp_start.push_back(s);
      if (to) begin
         last = k + T - 1;
         exp_abort.push_back(k + T);
         if (m_to < SAT) m_to++;
      end else begin
         last = k + d + 1 + (w < 0 ? 0 : w);
         t.ip = ip;
         t.mac = mac;
         t.res = res;
         t.data = data;
         t.cyc = last;
         exp_tx.push_back(t);
      end
      DATA_FRAME = data;
      SRC_IP_ADDRESS = ip;
      SRC_MAC_ADDRESS = mac;
      FRAME_READY = 1'b1;
      ACCEL_DONE = 1'b0;
      TX_READY = w < 0;
      chk("busy_idle", 64'(BUSY), 64'(0));
      tick();
      for (int c = k; c <= last; c++) begin
         if (c == k) chk("busy_start", 64'(BUSY), 64'(1));
         FRAME_READY = (c >= k + drop_from && c < k + drop_from + drop_n) ||
                       ($urandom_range(99) < 32'(drop_pct));
         if (FRAME_READY) drop_frame();
         ACCEL_DONE = !to && c == k + d;
         ACCEL_RESULT = ACCEL_DONE ? res : RW'($urandom);
         if (!to && c > k + d) ACCEL_DONE = 1'($urandom_range(1));
         if (!to && w >= 0) TX_READY = c >= k + d + 1 + w;
         tick();
      end
      FRAME_READY = 1'b0;
      ACCEL_DONE = 1'b0;
      TX_READY = 1'b0;
      chk("busy_after", 64'(BUSY), 64'(0));
      chk("drop_count", 64'(DROP_COUNT), 64'(m_drop));
      chk("timeout_count", 64'(TIMEOUT_COUNT), 64'(m_to));
   endtask
   task automatic chk_all_zero(string n);
      chk({n, "_start"}, 64'(ACCEL_START), 64'(0));
      chk_data({n, "_data"}, ACCEL_DATA, '0);
      chk({n, "_abort"}, 64'(ACCEL_ABORT), 64'(0));
      chk({n, "_valid"}, 64'(TX_VALID), 64'(0));
      chk({n, "_ip"}, 64'(TX_DST_IP), 64'(0));
      chk({n, "_mac"}, 64'(TX_DST_MAC), 64'(0));
      chk({n, "_result"}, 64'(TX_RESULT), 64'(0));
      chk({n, "_busy"}, 64'(BUSY), 64'(0));
      chk({n, "_drops"}, 64'(DROP_COUNT), 64'(0));
      chk({n, "_timeouts"}, 64'(TIMEOUT_COUNT), 64'(0));
   endtask
   initial begin
      logic [DW-1:0] ones;
      int g;
      st_t s;
      for (int j = 0; j < UB; j++) ones[j*8+:8] = 8'h01;
      #1 ARESET = 1'b1;
      #2 chk_all_zero("reset");
      tick();
      tick();
      ARESET = 1'b0;
      job(ones, 32'hcccccccc, 48'hdddddddddddd, 8'h07, 10, 0, 0, 0, 0);
      job(rnd_data(), $urandom, MW'({$urandom, $urandom}), 8'($urandom), 12, 1, 4, 1, 0);
      job(rnd_data(), $urandom, MW'({$urandom, $urandom}), 8'($urandom), T, -1, 0, 0, 0);
      job(rnd_data(), $urandom, MW'({$urandom, $urandom}), 8'($urandom), 6, 2, 0, 0, 0);
      job(rnd_data(), $urandom, MW'({$urandom, $urandom}), 8'($urandom), 5, 30, 15, 1, 0);
      job(rnd_data(), $urandom, MW'({$urandom, $urandom}), 8'($urandom), T - 1, 0, 0, 0, 0);
      job(rnd_data(), $urandom, MW'({$urandom, $urandom}), 8'($urandom), 1, -1, 0, 0, 0);
      for (int j = 0; j < 40; j++) begin
         g = $urandom_range(3);
         for (int i = 0; i < g; i++) begin
            ACCEL_DONE = 1'($urandom_range(1));
            ACCEL_RESULT = RW'($urandom);
            tick();
         end
         job(rnd_data(), $urandom, MW'({$urandom, $urandom}), RW'($urandom),
             $urandom_range(T + 2, 1), int'($urandom_range(6)) - 1, 1, 0, 15);
      end
      DATA_FRAME = rnd_data();
      SRC_IP_ADDRESS = $urandom | 32'h1;
      SRC_MAC_ADDRESS = MW'({$urandom, $urandom}) | 48'h1;
      s.data = DATA_FRAME;
      s.cyc = cyc + 1;
      exp_start.push_back(s);
      FRAME_READY = 1'b1;
      tick();
      FRAME_READY = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      #2 ARESET = 1'b1;
      #1 chk_all_zero("midreset");
      exp_tx.delete();
      exp_abort.delete();
      m_drop = 0;
      m_to = 0;
      tick();
      ARESET = 1'b0;
      ACCEL_DONE = 1'b1;
      TX_READY = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk("post_reset_valid", 64'(TX_VALID), 64'(0));
      chk("post_reset_busy", 64'(BUSY), 64'(0));
      ACCEL_DONE = 1'b0;
      TX_READY = 1'b0;
      job(rnd_data(), $urandom, MW'({$urandom, $urandom}), 8'($urandom), 10, 3, 1, 5, 0);
      chk("sat_drop_count", 64'(DROP_COUNT), 64'(3));
      tick();
      tick();
      chk("queues_drained", 64'(exp_start.size() + exp_tx.size() + exp_abort.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
   initial begin
      #1_000_000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end
endmodule
